// File: rtl/trig_sched_pkg.sv
// Shared definitions for the trig LUT scheduler: function codes, FSM state
// encoding, angle constants and the angle-to-quadrant reduction helper.
package trig_sched_pkg;

    // Function codes double as the bit position in the one-hot LUT enable.
    localparam logic [2:0] FUNC_SIN = 3'd0;
    localparam logic [2:0] FUNC_COS = 3'd1;
    localparam logic [2:0] FUNC_TAN = 3'd2;
    localparam logic [2:0] FUNC_CSC = 3'd3;
    localparam logic [2:0] FUNC_SEC = 3'd4;
    localparam logic [2:0] FUNC_COT = 3'd5;

    localparam int NUM_FUNCS = 6;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REDUCE  = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam logic [8:0] DEG_90  = 9'd90;
    localparam logic [8:0] DEG_180 = 9'd180;
    localparam logic [8:0] DEG_270 = 9'd270;
    localparam logic [8:0] DEG_360 = 9'd360;

    // Quadrant plus reference angle (0..90) handed to the LUT bank.
    typedef struct packed {
        logic [1:0] quad;
        logic [6:0] ref_deg;
    } reduced_t;

    // Inputs top out at 511, so a single subtraction of 360 is enough.
    function automatic reduced_t reduce_angle(input logic [8:0] angle);
        logic [8:0] a;
        reduced_t   r;
        a = (angle >= DEG_360) ? angle - DEG_360 : angle;
        if (a < DEG_90) begin
            r.quad    = 2'd0;
            r.ref_deg = 7'(a);
        end else if (a < DEG_180) begin
            r.quad    = 2'd1;
            r.ref_deg = 7'(DEG_180 - a);
        end else if (a < DEG_270) begin
            r.quad    = 2'd2;
            r.ref_deg = 7'(a - DEG_180);
        end else begin
            r.quad    = 2'd3;
            r.ref_deg = 7'(DEG_360 - a);
        end
        return r;
    endfunction

    function automatic logic func_is_valid(input logic [2:0] func);
        return func <= FUNC_COT;
    endfunction

endpackage

// File: rtl/trig_rr_arbiter.sv
// Round-robin arbiter: grants the first active requester strictly after the
// pointer, wrapping around. Purely combinational; the pointer lives in the
// caller so it only advances when a grant is actually taken.
module trig_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ) and keep the first hit.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/trig_lut_scheduler.sv
// Trig LUT scheduler: shares one six-function LUT bank between NUM_REQ
// requesters. Arbitrates round-robin, reduces the angle to quadrant and
// reference angle, pulses one LUT enable, captures the 64-bit result and
// returns it over a valid/ready handshake.
// Optional build macro TRIG_SCHED_STATS_EN adds saturating response counters
// stat_done / stat_err.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module trig_lut_scheduler
    import trig_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = `DATA_WIDTH,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*9-1:0]  req_angle,
    input  logic [NUM_REQ*3-1:0]  req_func,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_err,
    output logic [63:0]           rsp_data,
    output logic [NUM_FUNCS-1:0]  lut_en,
    output logic [1:0]            lut_quadrant,
    output logic [DATA_WIDTH-1:0] lut_data_in,
    input  logic [63:0]           lut_data_out,
    output logic                  busy
`ifdef TRIG_SCHED_STATS_EN
    ,
    output logic [31:0]           stat_done,
    output logic [15:0]           stat_err
`endif
);

    logic [2:0]         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [8:0]         angle_q, angle_d;
    logic [2:0]         func_q, func_d;
    logic [1:0]         quad_q, quad_d;
    logic [6:0]         ref_q, ref_d;
    logic               err_q, err_d;
    logic [63:0]        data_q, data_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    reduced_t           reduced;

    trig_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign reduced = reduce_angle(angle_q);

    // Next-state and datapath update for the request/response sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        angle_d = angle_q;
        func_d  = func_q;
        quad_d  = quad_q;
        ref_d   = ref_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    ptr_d   = grant_idx;
                    id_d    = grant_idx;
                    angle_d = req_angle[int'(grant_idx)*9 +: 9];
                    func_d  = req_func[int'(grant_idx)*3 +: 3];
                    err_d   = 1'b0;
                    data_d  = '0;
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                quad_d = reduced.quad;
                ref_d  = reduced.ref_deg;
                if (!func_is_valid(func_q)) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // The LUT registers its output, so the result of the ISSUE
                // cycle is on the bus now.
                data_d  = lut_data_out;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            angle_q <= '0;
            func_q  <= '0;
            quad_q  <= '0;
            ref_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            angle_q <= angle_d;
            func_q  <= func_d;
            quad_q  <= quad_d;
            ref_q   <= ref_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // Grants are only visible in IDLE and never while reset is held.
    assign req_ready    = (state_q == ST_IDLE && reset_n) ? grant : '0;

    // LUT interface is quiet except in ISSUE, where func is known valid.
    assign lut_en       = (state_q == ST_ISSUE) ? (6'd1 << func_q) : '0;
    assign lut_quadrant = (state_q == ST_ISSUE) ? quad_q : 2'd0;
    assign lut_data_in  = (state_q == ST_ISSUE) ? {{(DATA_WIDTH-7){1'b0}}, ref_q}
                                                : '0;

    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_id       = id_q;
    assign rsp_err      = err_q;
    assign rsp_data     = data_q;
    assign busy         = (state_q != ST_IDLE);

`ifdef TRIG_SCHED_STATS_EN
    logic [31:0] stat_done_q;
    logic [15:0] stat_err_q;

    // Saturating counters of completed and rejected responses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_done_q <= '0;
            stat_err_q  <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (err_q) begin
                if (!(&stat_err_q)) begin
                    stat_err_q <= stat_err_q + 16'd1;
                end
            end else if (!(&stat_done_q)) begin
                stat_done_q <= stat_done_q + 32'd1;
            end
        end
    end

    assign stat_done = stat_done_q;
    assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_trig_lut_scheduler.sv
// Scoreboard bench for trig_lut_scheduler: stimulus pushes expected LUT
// issues and responses computed from a plain-arithmetic model; monitors pop
// and compare when the DUT presents them.
module tb_trig_lut_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*9-1:0] req_angle;
    logic [N*3-1:0] req_func;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic          rsp_err;
    logic [63:0]   rsp_data;
    logic [5:0]    lut_en;
    logic [1:0]    lut_quadrant;
    logic [DW-1:0] lut_data_in;
    logic [63:0]   lut_data_out;
    logic          busy;

    trig_lut_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_angle(req_angle), .req_func(req_func),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .lut_en(lut_en), .lut_quadrant(lut_quadrant),
        .lut_data_in(lut_data_in), .lut_data_out(lut_data_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          func;
        int          quad;
        int          refd;
        bit          err;
        logic [63:0] data;
        int          t;
    } exp_t;

    exp_t        iss_q[$];
    exp_t        rsp_q[$];
    exp_t        cur;
    bit          cur_active;
    bit          outstanding;
    int          ptr;
    int          grant_log[$];
    int          cyc;
    int          n_checks;
    int          n_pass;
    bit          hold;
    bit          rnd_ready;
    logic [63:0] last_data;
    int          last_id;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference reduction: fold modulo 360, quadrant by 90-degree band.
    function automatic void model_reduce(input int a, output int q, output int r);
        int d;
        d = a % 360;
        q = d / 90;
        case (q)
            0:       r = d;
            1:       r = 180 - d;
            2:       r = d - 180;
            default: r = 360 - d;
        endcase
    endfunction

    // Synthetic LUT contents; one entry pinned to -2.0 for the directed case.
    function automatic logic [63:0] lut_val(input int f, input int q, input int r);
        if (f == 3 && q == 2 && r == 30) return 64'hC000000000000000;
        return {8'hA0 + 8'(f), 8'(q), 16'(r), 32'h5A5A_0000 + 32'(r * 7 + f * 3 + q)};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Registered LUT bank model; outside its valid cycle the bus carries junk.
    always @(posedge clk) begin
        int f;
        f = 0;
        for (int i = 5; i >= 0; i--) if (lut_en[i]) f = i;
        if (lut_en != 0) lut_data_out <= lut_val(f, int'(lut_quadrant), int'(lut_data_in));
        else             lut_data_out <= {$urandom, $urandom};
    end

    // Response-ready driver.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: arbitration model, LUT issue checks, response checks.
    always @(negedge clk) begin
        bit           out_now;
        int           g;
        logic [N-1:0] expg;
        logic [5:0]   exp_en;
        exp_t         e;
        if (!reset_n) begin
            iss_q.delete();
            rsp_q.delete();
            cur_active  = 0;
            outstanding = 0;
            ptr         = N - 1;
        end else begin
            out_now = outstanding;
            check("busy", busy, out_now);
            if (lut_en != 0) begin
                if (iss_q.size() == 0) begin
                    fail_now("lut_en_unexpected");
                end else begin
                    e = iss_q.pop_front();
                    exp_en = '0;
                    exp_en[e.func] = 1'b1;
                    check("lut_en", lut_en, exp_en);
                    check("lut_quadrant", lut_quadrant, e.quad);
                    check("lut_data_in", lut_data_in, e.refd);
                    check("issue_latency", cyc, e.t + 2);
                end
            end else begin
                check("lut_idle", {lut_quadrant, lut_data_in}, 0);
            end
            if (rsp_valid) begin
                if (!cur_active) begin
                    if (rsp_q.size() == 0) begin
                        fail_now("rsp_unexpected");
                    end else begin
                        cur = rsp_q.pop_front();
                        cur_active = 1;
                        check("rsp_latency", cyc, cur.t + (cur.err ? 2 : 4));
                    end
                end
                if (cur_active) begin
                    check("rsp_id", rsp_id, cur.id);
                    check("rsp_err", rsp_err, cur.err);
                    check("rsp_data", rsp_data, cur.data);
                    if (rsp_ready) begin
                        last_data   = rsp_data;
                        last_id     = int'(rsp_id);
                        cur_active  = 0;
                        outstanding = 0;
                    end
                end
            end else if (cur_active) begin
                fail_now("rsp_valid_dropped");
                cur_active = 0;
            end
            if (out_now) begin
                check("no_grant_while_busy", req_ready, 0);
            end else begin
                g = rr_pick(req_valid, ptr);
                expg = '0;
                if (g >= 0) expg[g] = 1'b1;
                check("grant", req_ready, expg);
                if (g >= 0) begin
                    e.id   = g;
                    e.func = int'(req_func[g*3 +: 3]);
                    model_reduce(int'(req_angle[g*9 +: 9]), e.quad, e.refd);
                    e.err  = (e.func > 5);
                    e.data = e.err ? 64'd0 : lut_val(e.func, e.quad, e.refd);
                    e.t    = cyc;
                    if (!e.err) iss_q.push_back(e);
                    rsp_q.push_back(e);
                    outstanding = 1;
                    ptr = g;
                    grant_log.push_back(g);
                end
            end
        end
    end

    task automatic load(input int i, input int fmax);
        req_angle[i*9 +: 9] = 9'($urandom_range(0, 511));
        req_func[i*3 +: 3]  = 3'($urandom_range(0, fmax));
        req_valid[i]        = 1'b1;
    endtask

    // Issue one request and wait for its grant; returns just after the accept.
    task automatic single(input int id, input int a, input int f);
        bit got;
        got = 0;
        @(posedge clk);
        #1;
        req_angle[id*9 +: 9] = 9'(a);
        req_func[id*3 +: 3]  = 3'(f);
        req_valid[id]        = 1'b1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        if (!got) fail_now("grant_timeout");
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    // Several requesters competing; each stays valid until granted.
    task automatic traffic(input int n, input logic [N-1:0] mask, input bit cont, input int fmax);
        int           granted;
        int           budget;
        logic [N-1:0] g;
        granted = 0;
        budget  = n * 40 + 100;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (mask[i]) load(i, fmax);
        while ((granted < n || req_valid != 0) && budget > 0) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            budget--;
            for (int i = 0; i < N; i++) if (g[i]) begin granted++; req_valid[i] = 1'b0; end
            for (int i = 0; i < N; i++) begin
                if (g[i] && mask[i] && granted + $countones(req_valid) < n &&
                    (cont || $urandom_range(0, 3) != 0)) load(i, fmax);
            end
            if (req_valid == 0 && granted < n) begin
                for (int i = 0; i < N; i++) if (mask[i] && req_valid == 0) load(i, fmax);
            end
        end
        if (budget == 0) begin
            fail_now("traffic_timeout");
            req_valid = '0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (!outstanding && !cur_active && rsp_q.size() == 0) return;
            @(negedge clk);
        end
        fail_now("drain_timeout");
    endtask

    initial begin
        int sweep[8];
        int exp_ord[5];
        bit seen;
        sweep   = '{0, 89, 90, 180, 270, 359, 360, 511};
        exp_ord = '{0, 1, 2, 3, 0};
        n_checks = 0; n_pass = 0; cyc = 0;
        hold = 0; rnd_ready = 0;
        reset_n = 1'b0; req_valid = '0; req_angle = '0; req_func = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_id}, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_lut", {lut_en, lut_quadrant, lut_data_in}, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed CSC at 210 degrees.
        single(0, 210, 3);
        drain();
        check("csc_data", last_data, 64'hC000000000000000);
        check("csc_id", last_id, 0);

        // Boundary sweep with SIN.
        foreach (sweep[i]) begin
            single(0, sweep[i], 0);
            drain();
        end

        // Invalid function code on requester 2.
        single(2, 100, 7);
        drain();
        check("err_data", last_data, 0);

        // Response back-pressure with another requester waiting.
        hold = 1;
        single(1, 45, 1);
        req_angle[3*9 +: 9] = 9'd300;
        req_func[3*3 +: 3]  = 3'd2;
        req_valid[3]        = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        if (!seen) fail_now("hold_rsp_timeout");
        repeat (10) @(posedge clk);
        hold = 0;
        single(3, 300, 2);
        drain();

        // Four requesters continuously valid.
        grant_log.delete();
        traffic(5, 4'b1111, 1'b1, 5);
        drain();
        if (grant_log.size() != 5) fail_now("rr_order_count");
        else foreach (exp_ord[i]) check("rr_order", grant_log[i], exp_ord[i]);

        // Randomized traffic with random back-pressure.
        rnd_ready = 1;
        repeat (30) traffic(5, 4'($urandom_range(1, 15)), 1'b0, 7);
        drain();
        rnd_ready = 0;

        // Reset while a LUT enable is being issued.
        single(1, 123, 0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (lut_en != 0) seen = 1;
        end
        if (!seen) fail_now("issue_timeout");
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_lut_en", lut_en, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        grant_log.delete();
        traffic(4, 4'b1111, 1'b1, 5);
        drain();
        if (grant_log.size() == 0) fail_now("rst_restart_no_grant");
        else check("rst_restart_first", grant_log[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trig_lut_scheduler.md
Name: trig_lut_scheduler

Overview:
- Shares one bank of six trig LUTs (sin, cos, tan, csc, sec, cot) between NUM_REQ requesters.
- Round-robin arbitrates requests and reduces a 0..511 degree angle to a quadrant and a 0..90 reference angle.
- Fires exactly one LUT enable for one cycle, captures the 64-bit double result and returns it with a valid/ready handshake.
- Sits between the core's issue logic and the LUT bank; the LUT bank drives z when not enabled.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, `DATA_WIDTH (32), width of LUT index input

Ports:
clk  in  1  clock
reset_n  in  1  reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_angle  in  NUM_REQ*9  packed angles in degrees, 0..511
req_func  in  NUM_REQ*3  packed function codes
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NUM_REQ)  index of the served requester
rsp_err  out  1  invalid function code
rsp_data  out  64  IEEE-754 double result
lut_en  out  6  one-hot LUT enable; bit = func code
lut_quadrant  out  2  quadrant to the LUT
lut_data_in  out  DATA_WIDTH  reference angle, zero-extended
lut_data_out  in  64  shared LUT result bus
busy  out  1  state != IDLE

Behaviour:
- Reset: reset_n, synchronous, active-low; clock clk.
- Reset values:
  - all outputs 0, state IDLE
  - rr pointer = NUM_REQ-1, so req 0 has first priority
  - reset mid-operation drops the in-flight request silently; lut_en is 0 on the next edge
- FSM states:
  - IDLE: if any req_valid, grant the first requester after the rr pointer (wrapping) by asserting req_ready[g] combinationally this cycle. Latch angle, func and id; pointer = g; go to REDUCE. No req_valid: stay.
  - REDUCE (T+1):
    - a' = a>=360 ? a-360 : a
    - q = 0 if a'<90; 1 if <180; 2 if <270; else 3
    - ref = a' (q0), 180-a' (q1), a'-180 (q2), 360-a' (q3)
    - register q and ref
    - func>5: set rsp_err, rsp_data=0, go to RESP; otherwise go to ISSUE
  - ISSUE (T+2): lut_en[func]=1 for exactly this cycle, with lut_quadrant=q and lut_data_in=ref held stable. Go to CAPTURE.
  - CAPTURE (T+3): rsp_data <= lut_data_out (LUT output is registered, so valid now). Go to RESP.
  - RESP (T+4 onward): rsp_valid=1; rsp_data, rsp_id and rsp_err held stable until rsp_ready. On handshake go to IDLE; the next grant is earliest one cycle later.
- Latency and throughput: accept to rsp_valid is 4 cycles; minimum 5 cycles per request.
- Requesters must hold req_valid, angle and func stable until req_ready.
- lut_en, lut_quadrant and lut_data_in are 0 outside ISSUE.
- Boundaries:
  - 90 → q1, ref 90
  - 180 → q2, ref 0
  - 270 → q3, ref 90
  - 359 → q3, ref 1
  - 360 → 0; 450 → 90; 511 → 151 → q1, ref 29
- Requests arriving while busy wait; no queueing.

Optional Feature:
TRIG_SCHED_STATS_EN:
- Defined: adds outputs stat_done[31:0] (incremented on each rsp handshake with rsp_err=0) and stat_err[15:0] (incremented on each rsp handshake with rsp_err=1). Both saturate and clear on reset.
- Undefined: ports and counters are absent.

Decomposition:
- Package trig_sched_pkg:
  - func codes FUNC_SIN=0, COS=1, TAN=2, CSC=3, SEC=4, COT=5
  - FSM state encoding
  - constants DEG_90/180/270/360
- Sub-module trig_rr_arbiter: NUM_REQ round-robin grant from a request vector and pointer.

Test Plan:
- req0 angle=210 func=CSC:
  - lut_en=6'b001000 at T+2, lut_quadrant=2, lut_data_in=30
  - LUT model returns 64'hC000000000000000
  - rsp_data equals that value, rsp_id=0, rsp_valid at T+4
- Angle sweep with func=SIN → (q, ref) pairs:
  - 0→(0,0), 89→(0,89), 90→(1,90), 180→(2,0)
  - 270→(3,90), 359→(3,1), 360→(0,0), 511→(1,29)
- All four requesters valid continuously → grants in order 0,1,2,3,0; each granted once per 4 responses.
- func=7 on req2 → no lut_en pulse, rsp_err=1, rsp_data=0, rsp_valid at T+2.
- rsp_ready held low 10 cycles → rsp_valid, rsp_data and rsp_id stable; no new req_ready until the handshake.
- reset_n low during ISSUE → next cycle lut_en=0, rsp_valid=0, busy=0; the rr pointer restarts so req0 wins first.
